// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory requests from EX/MEM, stalls the front of
// the pipe until dhit, and produces the MEM/WB latch (result, bubble or halt marker).
//
// state  | meaning
// IDLE   | no outstanding data access
// ACCESS | request outstanding, waiting for dhit
// HALTED | halt retired; terminal until RST
module mem_stage_ctrl #(
   parameter int WORD_W = 32,
   parameter int SEL_W  = 5,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              exValid,
   input  logic [WORD_W-1:0] exinstr,
   input  logic [WORD_W-1:0] exOutput_Port,
   input  logic [WORD_W-1:0] exrdat2,
   input  logic [SEL_W-1:0]  exwsel,
   input  logic              exWEN,
   input  logic              exMemToReg,
   input  logic              exDRE,
   input  logic              exDWE,
   input  logic              exHALT,
   input  logic              exLUIflag,
   input  logic [WORD_W-1:0] exLUIdata,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic              memStall,
   output logic              wbMemToReg,
   output logic              wbWEN,
   output logic              wbLUIflag,
   output logic              wbHALT,
   output logic [SEL_W-1:0]  wbwsel,
   output logic [WORD_W-1:0] wbOutput_Port,
   output logic [WORD_W-1:0] wbdmemload,
   output logic [WORD_W-1:0] wbinstr,
   output logic [WORD_W-1:0] wbLUIdata,
   output logic [CNT_W-1:0]  stallCycles
);

   typedef enum logic [1:0] {IDLE, ACCESS, HALTED} stateT;

   stateT state;
   logic  running;
   logic  memOp;
   logic  isWrite;
   logic  isRead;
   logic  haltNow;
   logic  complete;

   // A store wins over a load when both enables are set.
   always_comb begin
      running  = (state != HALTED);
      memOp    = exValid & (exDRE | exDWE) & ~exHALT;
      isWrite  = memOp & exDWE;
      isRead   = memOp & exDRE & ~exDWE;
      haltNow  = running & exValid & exHALT;
      complete = running & ((exValid & ~memOp & ~exHALT) | (memOp & dhit));
   end

   assign dmemWEN   = ~RST & running & isWrite;
   assign dmemREN   = ~RST & running & isRead;
   assign dmemaddr  = exOutput_Port;
   assign dmemstore = exrdat2;
   assign memStall  = ~running | (memOp & ~dhit);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         stallCycles   <= '0;
         wbMemToReg    <= 1'b0;
         wbWEN         <= 1'b0;
         wbLUIflag     <= 1'b0;
         wbHALT        <= 1'b0;
         wbwsel        <= '0;
         wbOutput_Port <= '0;
         wbdmemload    <= '0;
         wbinstr       <= '0;
         wbLUIdata     <= '0;
      end else begin
         if (memStall && !(&stallCycles))
            stallCycles <= stallCycles + CNT_W'(1);

         case (state)
            IDLE: begin
               if (haltNow)
                  state <= HALTED;
               else if (memOp && !dhit)
                  state <= ACCESS;
            end
            ACCESS: begin
               if (haltNow)
                  state <= HALTED;
               else if (dhit)
                  state <= IDLE;
            end
            default: state <= HALTED;
         endcase

         if (complete) begin
            wbMemToReg    <= exMemToReg;
            wbWEN         <= exWEN;
            wbLUIflag     <= exLUIflag;
            wbHALT        <= 1'b0;
            wbwsel        <= exwsel;
            wbOutput_Port <= exOutput_Port;
            wbdmemload    <= isRead ? dmemload : '0;
            wbinstr       <= exinstr;
            wbLUIdata     <= exLUIdata;
         end else begin
            // Bubble; a halt tags it with its instruction word, and wbHALT is sticky.
            wbMemToReg    <= 1'b0;
            wbWEN         <= 1'b0;
            wbLUIflag     <= 1'b0;
            wbHALT        <= haltNow | wbHALT;
            wbwsel        <= '0;
            wbOutput_Port <= '0;
            wbdmemload    <= '0;
            wbinstr       <= haltNow ? exinstr : '0;
            wbLUIdata     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: vector table, directed multi-cycle sequences, and
// randomized traffic against a rule-level reference model.
module tb_mem_stage_ctrl;
   localparam int WORD_W = 32;
   localparam int SEL_W  = 5;
   localparam int CNT_W  = 4;

   logic CLK = 1'b0;
   logic RST;
   logic exValid, exWEN, exMemToReg, exDRE, exDWE, exHALT, exLUIflag, dhit;
   logic [WORD_W-1:0] exinstr, exOutput_Port, exrdat2, exLUIdata, dmemload;
   logic [SEL_W-1:0]  exwsel;
   logic dmemREN, dmemWEN, memStall, wbMemToReg, wbWEN, wbLUIflag, wbHALT;
   logic [WORD_W-1:0] dmemaddr, dmemstore, wbOutput_Port, wbdmemload, wbinstr, wbLUIdata;
   logic [SEL_W-1:0]  wbwsel;
   logic [CNT_W-1:0]  stallCycles;

   int nCmp  = 0;
   int nFail = 0;

   // reference model state
   logic              mHalted;
   logic [CNT_W-1:0]  mCnt;
   logic              mM2r, mWen, mLui, mHalt;
   logic [SEL_W-1:0]  mWsel;
   logic [WORD_W-1:0] mPort, mLoad, mInstr, mLuiData;

   always #5 CLK = ~CLK;

   mem_stage_ctrl #(.WORD_W(WORD_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .exValid(exValid), .exinstr(exinstr),
      .exOutput_Port(exOutput_Port), .exrdat2(exrdat2), .exwsel(exwsel),
      .exWEN(exWEN), .exMemToReg(exMemToReg), .exDRE(exDRE), .exDWE(exDWE),
      .exHALT(exHALT), .exLUIflag(exLUIflag), .exLUIdata(exLUIdata),
      .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .memStall(memStall),
      .wbMemToReg(wbMemToReg), .wbWEN(wbWEN), .wbLUIflag(wbLUIflag),
      .wbHALT(wbHALT), .wbwsel(wbwsel), .wbOutput_Port(wbOutput_Port),
      .wbdmemload(wbdmemload), .wbinstr(wbinstr), .wbLUIdata(wbLUIdata),
      .stallCycles(stallCycles)
   );

   typedef struct packed {
      logic        valid, dre, dwe, hit, wen, m2r, lui;
      logic [4:0]  wsel;
      logic [31:0] port, rdat2, load, luiData, instr;
      logic        eRen, eWen, eStall, eDone;
      logic [31:0] eLoad;
   } vecT;

   vecT vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clearIn();
      exValid = 0; exWEN = 0; exMemToReg = 0; exDRE = 0; exDWE = 0; exHALT = 0;
      exLUIflag = 0; dhit = 0; exinstr = 0; exOutput_Port = 0; exrdat2 = 0;
      exLUIdata = 0; dmemload = 0; exwsel = 0;
   endtask

   task automatic doReset();
      RST = 1; clearIn();
      tick();
      RST = 0;
   endtask

   task automatic setLoad(input logic [31:0] addr);
      clearIn();
      exValid = 1; exDRE = 1; exWEN = 1; exMemToReg = 1; exwsel = 5'd7;
      exOutput_Port = addr;
   endtask

   task automatic mBubble();
      mM2r = 0; mWen = 0; mLui = 0; mWsel = '0;
      mPort = '0; mLoad = '0; mInstr = '0; mLuiData = '0;
   endtask

   task automatic checkModelWb();
      chk("rnd.wbWEN", wbWEN, mWen);
      chk("rnd.wbMemToReg", wbMemToReg, mM2r);
      chk("rnd.wbLUIflag", wbLUIflag, mLui);
      chk("rnd.wbHALT", wbHALT, mHalt);
      chk("rnd.wbwsel", wbwsel, mWsel);
      chk("rnd.wbOutput_Port", wbOutput_Port, mPort);
      chk("rnd.wbdmemload", wbdmemload, mLoad);
      chk("rnd.wbinstr", wbinstr, mInstr);
      chk("rnd.wbLUIdata", wbLUIdata, mLuiData);
      chk("rnd.stallCycles", stallCycles, mCnt);
   endtask

   task automatic randCycle();
      logic mop, eRen, eWen, eStall;
      RST           = ($urandom_range(39) == 0);
      exValid       = ($urandom_range(3) != 0);
      exDRE         = $urandom_range(1);
      exDWE         = ($urandom_range(2) == 0);
      exHALT        = ($urandom_range(29) == 0);
      exWEN         = $urandom_range(1);
      exMemToReg    = $urandom_range(1);
      exLUIflag     = $urandom_range(1);
      dhit          = $urandom_range(1);
      exwsel        = SEL_W'($urandom);
      exinstr       = $urandom;
      exOutput_Port = $urandom;
      exrdat2       = $urandom;
      exLUIdata     = $urandom;
      dmemload      = $urandom;
      #1;
      mop    = exValid && (exDRE || exDWE) && !exHALT;
      eWen   = !RST && !mHalted && mop && exDWE;
      eRen   = !RST && !mHalted && mop && exDRE && !exDWE;
      eStall = mHalted || (mop && !dhit);
      chk("rnd.dmemREN", dmemREN, eRen);
      chk("rnd.dmemWEN", dmemWEN, eWen);
      chk("rnd.memStall", memStall, eStall);
      chk("rnd.dmemaddr", dmemaddr, exOutput_Port);
      chk("rnd.dmemstore", dmemstore, exrdat2);
      if (RST) begin
         mHalted = 0; mCnt = '0; mHalt = 0; mBubble();
      end else begin
         if (eStall && mCnt != {CNT_W{1'b1}}) mCnt = mCnt + 1'b1;
         if (!mHalted && exValid && exHALT) begin
            mBubble(); mHalt = 1; mInstr = exinstr; mHalted = 1;
         end else if (!mHalted && ((exValid && !mop) || (mop && dhit))) begin
            mM2r = exMemToReg; mWen = exWEN; mLui = exLUIflag; mWsel = exwsel;
            mPort = exOutput_Port; mInstr = exinstr; mLuiData = exLUIdata;
            mLoad = eRen ? dmemload : '0; mHalt = 0;
         end else begin
            mBubble();
         end
      end
      tick();
      checkModelWb();
   endtask

   initial begin
      //            valid dre dwe hit wen m2r lui wsel  port      rdat2     load          luiData       instr      eRen eWen eStall eDone eLoad
      vecs[0] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd5,32'h1234,32'h0,  32'h0,        32'h0,        32'h11, 1'b0,1'b0,1'b0,1'b1,32'h0};
      vecs[1] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h40,  32'h55, 32'h99,       32'h0,        32'h22, 1'b0,1'b1,1'b0,1'b1,32'h0};
      vecs[2] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,5'd2,32'h44,  32'h66, 32'h77,       32'h0,        32'h33, 1'b0,1'b1,1'b0,1'b1,32'h0};
      vecs[3] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,5'd9,32'h88,  32'h0,  32'h0,        32'h0,        32'h44, 1'b1,1'b0,1'b1,1'b0,32'h0};
      vecs[4] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,5'd9,32'h88,  32'h0,  32'hCAFEF00D, 32'h0,        32'h44, 1'b1,1'b0,1'b0,1'b1,32'hCAFEF00D};
      vecs[5] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,5'd3,32'h0,   32'h0,  32'h0,        32'hABCD0000, 32'h55, 1'b0,1'b0,1'b0,1'b1,32'h0};
      vecs[6] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,5'd7,32'h90,  32'h0,  32'h12,       32'h1,        32'h66, 1'b0,1'b0,1'b0,1'b0,32'h0};

      // reset overrides a live load request
      RST = 1; clearIn();
      setLoad(32'h80);
      #1;
      chk("rst.dmemREN", dmemREN, 0);
      chk("rst.dmemWEN", dmemWEN, 0);
      tick(); tick();
      chk("rst.wbWEN", wbWEN, 0);
      chk("rst.wbHALT", wbHALT, 0);
      chk("rst.wbOutput_Port", wbOutput_Port, 0);
      chk("rst.wbinstr", wbinstr, 0);
      chk("rst.stallCycles", stallCycles, 0);
      RST = 0;

      // load with dhit three cycles after the request
      setLoad(32'h80);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin dhit = 1; dmemload = 32'hDEADBEEF; end
         #1;
         chk("ld3.dmemREN", dmemREN, 1);
         chk("ld3.dmemaddr", dmemaddr, 32'h80);
         chk("ld3.memStall", memStall, (k < 3));
         tick();
         chk("ld3.wbWEN", wbWEN, (k == 3));
         chk("ld3.wbMemToReg", wbMemToReg, (k == 3));
         chk("ld3.wbdmemload", wbdmemload, (k == 3) ? 32'hDEADBEEF : 32'h0);
      end
      chk("ld3.stallCycles", stallCycles, 3);
      clearIn();

      foreach (vecs[i]) begin
         exValid = vecs[i].valid; exDRE = vecs[i].dre; exDWE = vecs[i].dwe;
         dhit = vecs[i].hit; exWEN = vecs[i].wen; exMemToReg = vecs[i].m2r;
         exLUIflag = vecs[i].lui; exwsel = vecs[i].wsel; exOutput_Port = vecs[i].port;
         exrdat2 = vecs[i].rdat2; dmemload = vecs[i].load; exLUIdata = vecs[i].luiData;
         exinstr = vecs[i].instr; exHALT = 0;
         #1;
         chk($sformatf("vec%0d.dmemREN", i), dmemREN, vecs[i].eRen);
         chk($sformatf("vec%0d.dmemWEN", i), dmemWEN, vecs[i].eWen);
         chk($sformatf("vec%0d.memStall", i), memStall, vecs[i].eStall);
         chk($sformatf("vec%0d.dmemaddr", i), dmemaddr, vecs[i].port);
         chk($sformatf("vec%0d.dmemstore", i), dmemstore, vecs[i].rdat2);
         tick();
         chk($sformatf("vec%0d.wbWEN", i), wbWEN, vecs[i].eDone & vecs[i].wen);
         chk($sformatf("vec%0d.wbMemToReg", i), wbMemToReg, vecs[i].eDone & vecs[i].m2r);
         chk($sformatf("vec%0d.wbLUIflag", i), wbLUIflag, vecs[i].eDone & vecs[i].lui);
         chk($sformatf("vec%0d.wbwsel", i), wbwsel, vecs[i].eDone ? vecs[i].wsel : 5'd0);
         chk($sformatf("vec%0d.wbOutput_Port", i), wbOutput_Port, vecs[i].eDone ? vecs[i].port : 32'h0);
         chk($sformatf("vec%0d.wbinstr", i), wbinstr, vecs[i].eDone ? vecs[i].instr : 32'h0);
         chk($sformatf("vec%0d.wbLUIdata", i), wbLUIdata, vecs[i].eDone ? vecs[i].luiData : 32'h0);
         chk($sformatf("vec%0d.wbdmemload", i), wbdmemload, vecs[i].eLoad);
         chk($sformatf("vec%0d.wbHALT", i), wbHALT, 0);
      end
      clearIn();

      // halt is sticky and blocks later requests
      exValid = 1; exHALT = 1; exinstr = 32'hABCD; exWEN = 1; exwsel = 5'd4;
      tick();
      clearIn();
      #1;
      chk("halt.wbHALT", wbHALT, 1);
      chk("halt.wbinstr", wbinstr, 32'hABCD);
      chk("halt.wbWEN", wbWEN, 0);
      chk("halt.memStall", memStall, 1);
      for (int k = 0; k < 3; k++) begin
         exValid = 1; exDRE = (k != 1); exDWE = (k == 1); dhit = 1; exWEN = 1;
         exOutput_Port = 32'h100 + k;
         #1;
         chk("halt.dmemREN", dmemREN, 0);
         chk("halt.dmemWEN", dmemWEN, 0);
         chk("halt.memStall", memStall, 1);
         tick();
         chk("halt.wbHALT", wbHALT, 1);
         chk("halt.wbWEN", wbWEN, 0);
      end
      doReset();
      chk("halt.rst.wbHALT", wbHALT, 0);
      chk("halt.rst.memStall", memStall, 0);

      // reset two cycles into a load
      setLoad(32'h200);
      tick(); tick();
      chk("rstacc.stallCycles", stallCycles, 2);
      RST = 1;
      #1;
      chk("rstacc.dmemREN", dmemREN, 0);
      tick();
      RST = 0; clearIn();
      #1;
      chk("rstacc.dmemREN", dmemREN, 0);
      chk("rstacc.memStall", memStall, 0);
      chk("rstacc.wbWEN", wbWEN, 0);
      chk("rstacc.wbMemToReg", wbMemToReg, 0);
      chk("rstacc.wbdmemload", wbdmemload, 0);
      chk("rstacc.stallCycles", stallCycles, 0);

      // stall counter saturates at all-ones
      setLoad(32'h300);
      for (int k = 0; k < 15; k++) tick();
      chk("sat.stallCycles15", stallCycles, 15);
      for (int k = 0; k < 5; k++) tick();
      chk("sat.stallCycles20", stallCycles, 15);
      dhit = 1; dmemload = 32'h5A5A;
      tick();
      chk("sat.wbdmemload", wbdmemload, 32'h5A5A);
      chk("sat.stallCycles", stallCycles, 15);

      doReset();
      mHalted = 0; mCnt = '0; mHalt = 0; mBubble();
      for (int n = 0; n < 500; n++) randCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end
endmodule
